// File: rtl/sampling_layer1_collector_pkg.sv
// Shared constants and types for the layer-1 sampling collector.
//   DATA_W     : pixel width per channel
//   MAP_PIXELS : pixels per channel per frame (14x14 pooled map)
//   ADDR_W     : storage address width (2**ADDR_W >= MAP_PIXELS)
//   CNT_W      : width of the frame pixel counter (can reach MAP_PIXELS)
//   CHANNELS   : number of feature-map channels
package sampling_layer1_collector_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned MAP_PIXELS = 196;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned CNT_W      = ADDR_W + 1;
  localparam int unsigned CHANNELS   = 6;

  typedef logic [DATA_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/sampling_collect_bank.sv
// Single-channel MAP_PIXELS x DATA_W feature-map memory.
// One synchronous write port, one synchronous read port; a read and write in
// the same cycle to the same address returns the old contents.
// Reads at addresses >= MAP_PIXELS return zero. Read data holds when idle.
// Optional macro SAMPLING_COLLECT_RELU_EN: negative (MSB=1) pixels stored as 0.
// Ports:
//   clk, rst            : clock, synchronous active-high reset (read data only)
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr       : read request
//   rd_data             : registered read data
module sampling_collect_bank
  import sampling_layer1_collector_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  pixel_t            wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output pixel_t            rd_data
);

  pixel_t mem [MAP_PIXELS];
  pixel_t store_data;

  // Value actually committed to storage
  always_comb begin
`ifdef SAMPLING_COLLECT_RELU_EN
    store_data = wr_data[DATA_W-1] ? '0 : wr_data;
`else
    store_data = wr_data;
`endif
  end

  // Storage array is intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= store_data;
    end
  end

  // Read port; non-blocking update gives read-before-write on collision
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (rd_addr < ADDR_W'(MAP_PIXELS)) ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/sampling_layer1_collector.sv
// Collects one 6-channel pooled feature map from the layer-1 sampling stage,
// checks the frame pixel count and serves 1-cycle-latency random reads to the
// layer-2 convolution address generator.
// Optional macro SAMPLING_COLLECT_RELU_EN: ReLU applied on write in each bank.
// Ports:
//   Clock, Input_Reset         : clock, synchronous active-high reset
//   Input_Valid, Input_Finish  : pixel strobe, frame-end strobe
//   Input_Pixel_1..6           : channel pixels
//   Read_Enable, Read_Address  : read request (served only in DONE)
//   Output_Pixel_1..6          : read data
//   Output_Valid               : read data valid
//   Capture_Done               : full frame stored and readable
//   Count_Error                : sticky, frame pixel count != MAP_PIXELS
//   Pixel_Count                : pixels written in the current frame
module sampling_layer1_collector
  import sampling_layer1_collector_pkg::*;
(
  input  logic              Clock,
  input  logic              Input_Reset,
  input  logic              Input_Valid,
  input  logic              Input_Finish,
  input  logic [DATA_W-1:0] Input_Pixel_1,
  input  logic [DATA_W-1:0] Input_Pixel_2,
  input  logic [DATA_W-1:0] Input_Pixel_3,
  input  logic [DATA_W-1:0] Input_Pixel_4,
  input  logic [DATA_W-1:0] Input_Pixel_5,
  input  logic [DATA_W-1:0] Input_Pixel_6,
  input  logic              Read_Enable,
  input  logic [ADDR_W-1:0] Read_Address,
  output logic [DATA_W-1:0] Output_Pixel_1,
  output logic [DATA_W-1:0] Output_Pixel_2,
  output logic [DATA_W-1:0] Output_Pixel_3,
  output logic [DATA_W-1:0] Output_Pixel_4,
  output logic [DATA_W-1:0] Output_Pixel_5,
  output logic [DATA_W-1:0] Output_Pixel_6,
  output logic              Output_Valid,
  output logic              Capture_Done,
  output logic              Count_Error,
  output logic [CNT_W-1:0]  Pixel_Count
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_d;
  logic              error_d;
  logic              wr_en_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic              rd_en_c;

  pixel_t pix_in  [CHANNELS];
  pixel_t pix_out [CHANNELS];

  assign pix_in[0] = Input_Pixel_1;
  assign pix_in[1] = Input_Pixel_2;
  assign pix_in[2] = Input_Pixel_3;
  assign pix_in[3] = Input_Pixel_4;
  assign pix_in[4] = Input_Pixel_5;
  assign pix_in[5] = Input_Pixel_6;

  assign Output_Pixel_1 = pix_out[0];
  assign Output_Pixel_2 = pix_out[1];
  assign Output_Pixel_3 = pix_out[2];
  assign Output_Pixel_4 = pix_out[3];
  assign Output_Pixel_5 = pix_out[4];
  assign Output_Pixel_6 = pix_out[5];

  // Reads only honoured once a frame is complete
  assign rd_en_c = Read_Enable && (state_q == DONE);

  // State, counter and status registers
  always_ff @(posedge Clock) begin
    if (Input_Reset) begin
      state_q      <= IDLE;
      Pixel_Count  <= '0;
      Count_Error  <= 1'b0;
      Capture_Done <= 1'b0;
      Output_Valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      Pixel_Count  <= count_d;
      Count_Error  <= error_d;
      Capture_Done <= (state_d == DONE);
      Output_Valid <= rd_en_c;
    end
  end

  // Next-state, counter, error and write-port decode
  always_comb begin
    state_d   = state_q;
    count_d   = Pixel_Count;
    error_d   = Count_Error;
    wr_en_c   = 1'b0;
    wr_addr_c = '0;
    unique case (state_q)
      IDLE: begin
        if (Input_Valid) begin
          wr_en_c = 1'b1;
          count_d = CNT_W'(1);
          error_d = 1'b0;
          state_d = CAPTURE;
        end else if (Input_Finish) begin
          // Empty frame
          error_d = 1'b1;
          state_d = DONE;
        end
      end
      CAPTURE: begin
        if (Input_Valid) begin
          if (Pixel_Count < CNT_W'(MAP_PIXELS)) begin
            wr_en_c   = 1'b1;
            wr_addr_c = Pixel_Count[ADDR_W-1:0];
            count_d   = Pixel_Count + CNT_W'(1);
          end else begin
            // Overflow: pixel dropped, count held
            error_d = 1'b1;
          end
        end
        // Uses the post-increment count when Valid and Finish coincide
        if (Input_Finish) begin
          state_d = DONE;
          if (count_d != CNT_W'(MAP_PIXELS)) begin
            error_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (Input_Valid) begin
          wr_en_c = 1'b1;
          count_d = CNT_W'(1);
          error_d = 1'b0;
          state_d = CAPTURE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One memory bank per channel
  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_bank
    sampling_collect_bank u_bank (
      .clk     (Clock),
      .rst     (Input_Reset),
      .wr_en   (wr_en_c),
      .wr_addr (wr_addr_c),
      .wr_data (pix_in[g]),
      .rd_en   (rd_en_c),
      .rd_addr (Read_Address),
      .rd_data (pix_out[g])
    );
  end

endmodule

// File: tb/tb_sampling_layer1_collector.sv
// Self-checking bench for sampling_layer1_collector: a reference memory model
// is updated as pixels are driven, expected read data is queued when a read is
// issued and compared when Output_Valid is seen.
module tb_sampling_layer1_collector;

  localparam int NPIX = 196;

  logic        Clock = 1'b0;
  logic        Input_Reset = 1'b0;
  logic        Input_Valid = 1'b0;
  logic        Input_Finish = 1'b0;
  logic [15:0] Input_Pixel_1 = '0, Input_Pixel_2 = '0, Input_Pixel_3 = '0;
  logic [15:0] Input_Pixel_4 = '0, Input_Pixel_5 = '0, Input_Pixel_6 = '0;
  logic        Read_Enable = 1'b0;
  logic [7:0]  Read_Address = '0;
  logic [15:0] Output_Pixel_1, Output_Pixel_2, Output_Pixel_3;
  logic [15:0] Output_Pixel_4, Output_Pixel_5, Output_Pixel_6;
  logic        Output_Valid, Capture_Done, Count_Error;
  logic [8:0]  Pixel_Count;

  sampling_layer1_collector dut (
    .Clock          (Clock),
    .Input_Reset    (Input_Reset),
    .Input_Valid    (Input_Valid),
    .Input_Finish   (Input_Finish),
    .Input_Pixel_1  (Input_Pixel_1),
    .Input_Pixel_2  (Input_Pixel_2),
    .Input_Pixel_3  (Input_Pixel_3),
    .Input_Pixel_4  (Input_Pixel_4),
    .Input_Pixel_5  (Input_Pixel_5),
    .Input_Pixel_6  (Input_Pixel_6),
    .Read_Enable    (Read_Enable),
    .Read_Address   (Read_Address),
    .Output_Pixel_1 (Output_Pixel_1),
    .Output_Pixel_2 (Output_Pixel_2),
    .Output_Pixel_3 (Output_Pixel_3),
    .Output_Pixel_4 (Output_Pixel_4),
    .Output_Pixel_5 (Output_Pixel_5),
    .Output_Pixel_6 (Output_Pixel_6),
    .Output_Valid   (Output_Valid),
    .Capture_Done   (Capture_Done),
    .Count_Error    (Count_Error),
    .Pixel_Count    (Pixel_Count)
  );

  always #5 Clock = ~Clock;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference storage: six channels, packed as {ch6..ch1} per address
  logic [95:0] mdl [NPIX];
  int          mcount = 0;
  logic [95:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef SAMPLING_COLLECT_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [95:0] pat(input int i, input int off);
    logic [95:0] v;
    for (int k = 1; k <= 6; k++) v[(k-1)*16 +: 16] = 16'(k*1000 + i + off);
    return v;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Drive one 6-channel pixel; model writes only while the frame has room
  task automatic send_pixel(input logic [95:0] v, input bit fin);
    Input_Valid   = 1'b1;
    Input_Finish  = fin;
    Input_Pixel_1 = v[15:0];
    Input_Pixel_2 = v[31:16];
    Input_Pixel_3 = v[47:32];
    Input_Pixel_4 = v[63:48];
    Input_Pixel_5 = v[79:64];
    Input_Pixel_6 = v[95:80];
    if (mcount < NPIX) begin
      for (int k = 0; k < 6; k++) mdl[mcount][k*16 +: 16] = relu(v[k*16 +: 16]);
      mcount++;
    end
    tick();
    Input_Valid  = 1'b0;
    Input_Finish = 1'b0;
  endtask

  task automatic send_finish();
    Input_Finish = 1'b1;
    tick();
    Input_Finish = 1'b0;
  endtask

  task automatic send_frame(input int n, input int off, input bit fin_last);
    mcount = 0;
    for (int i = 0; i < n; i++) send_pixel(pat(i, off), fin_last && (i == n - 1));
    if (!fin_last) send_finish();
  endtask

  // Issue a read in DONE and queue the expected data
  task automatic do_read(input int addr);
    Read_Enable  = 1'b1;
    Read_Address = 8'(addr);
    exp_q.push_back((addr < NPIX) ? mdl[addr] : 96'h0);
    tick();
    Read_Enable = 1'b0;
  endtask

  task automatic check_status(input string tag, input bit done, input bit err, input int cnt);
    check_eq({tag, "_done"}, 96'(Capture_Done), 96'(done));
    check_eq({tag, "_err"},  96'(Count_Error),  96'(err));
    check_eq({tag, "_cnt"},  96'(Pixel_Count),  96'(cnt));
  endtask

  // Scoreboard: every valid read beat must match the oldest queued read
  always @(negedge Clock) begin
    if (Output_Valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_valid", 96'(1), 96'(0));
      end else begin
        check_eq("sb_read_data",
                 {Output_Pixel_6, Output_Pixel_5, Output_Pixel_4,
                  Output_Pixel_3, Output_Pixel_2, Output_Pixel_1},
                 exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [95:0] v;
    for (int a = 0; a < NPIX; a++) mdl[a] = 'x;

    // Reset state
    Input_Reset = 1'b1;
    tick();
    Input_Reset = 1'b0;
    check_status("reset", 1'b0, 1'b0, 0);
    check_eq("reset_ovalid", 96'(Output_Valid), 96'(0));
    check_eq("reset_opix", 96'({Output_Pixel_1, Output_Pixel_6}), 96'(0));

    // Nominal frame
    send_frame(NPIX, 0, 1'b0);
    check_status("nominal", 1'b1, 1'b0, 196);
    do_read(37);
    check_eq("nominal_ovalid", 96'(Output_Valid), 96'(1));
    check_eq("nominal_ch3", 96'(Output_Pixel_3), 96'(3037));

    // Out-of-range and back-to-back reads
    do_read(196);
    do_read(0);
    do_read(1);
    do_read(2);
    tick();
    check_eq("idle_ovalid", 96'(Output_Valid), 96'(0));

    // Short frame; first pixel collides with a read of address 0 (old data)
    Read_Enable  = 1'b1;
    Read_Address = 8'd0;
    exp_q.push_back(mdl[0]);
    mcount = 0;
    send_pixel(pat(0, 10000), 1'b0);
    Read_Enable = 1'b0;
    check_status("newframe", 1'b0, 1'b0, 1);
    for (int i = 1; i < 150; i++) begin
      Read_Enable = (i == 10);
      send_pixel(pat(i, 10000), 1'b0);
      Read_Enable = 1'b0;
      if (i == 10) check_eq("capture_read_ovalid", 96'(Output_Valid), 96'(0));
    end
    send_finish();
    check_status("short", 1'b1, 1'b1, 150);
    do_read(149);
    do_read(150);

    // Long frame: 200 pixels, only the first 196 kept
    send_frame(200, 20000, 1'b0);
    check_status("long", 1'b1, 1'b1, 196);
    do_read(195);
    check_eq("long_last_ch1", 96'(Output_Pixel_1), 96'(16'(1000 + 195 + 20000)));

    // Valid and Finish together on the 196th pixel
    send_frame(NPIX, 30000, 1'b1);
    check_status("vf_same", 1'b1, 1'b0, 196);
    do_read(195);
    do_read(100);

    // Read issued in the reset cycle yields nothing
    Read_Enable  = 1'b1;
    Read_Address = 8'd5;
    Input_Reset  = 1'b1;
    tick();
    Input_Reset = 1'b0;
    Read_Enable = 1'b0;
    check_eq("reset_read_ovalid", 96'(Output_Valid), 96'(0));
    check_status("reset_done", 1'b0, 1'b0, 0);

    // Reset at pixel 100 mid-frame, then a complete frame
    mcount = 0;
    for (int i = 0; i < 100; i++) send_pixel(pat(i, 40000), 1'b0);
    check_status("midframe", 1'b0, 1'b0, 100);
    Input_Reset = 1'b1;
    tick();
    Input_Reset = 1'b0;
    check_status("midreset", 1'b0, 1'b0, 0);
    send_frame(NPIX, 50000, 1'b0);
    check_status("after_reset", 1'b1, 1'b0, 196);
    do_read(0);
    do_read(150);

    // Sign handling: negative and positive pixels at addresses 0 and 1
    mcount = 0;
    for (int i = 0; i < NPIX; i++) begin
      v = pat(i, 0);
      if (i == 0) v = {6{16'hFF38}};
      if (i == 1) v = {6{16'h00C8}};
      send_pixel(v, 1'b0);
    end
    send_finish();
    check_status("sign", 1'b1, 1'b0, 196);
    do_read(0);
`ifdef SAMPLING_COLLECT_RELU_EN
    check_eq("sign_neg_ch1", 96'(Output_Pixel_1), 96'(16'h0000));
`else
    check_eq("sign_neg_ch1", 96'(Output_Pixel_1), 96'(16'hFF38));
`endif
    do_read(1);
    check_eq("sign_pos_ch6", 96'(Output_Pixel_6), 96'(16'h00C8));

    tick();
    tick();
    check_eq("sb_drained", 96'(exp_q.size()), 96'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
